// File: rtl/gpo_core_buffered.sv
// Timed GPO output core with a small FIFO in front of the downstream path.
// Adds registered override, sticky error flags, a saturating drop counter and a FIFO level report.
module gpo_core_buffered #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned OVR_WIDTH  = 64,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         CLK100MHZ,
    input  logic                         resetn,
    input  logic                         counter_matched,
    input  logic [DATA_WIDTH-1:0]        gpo_in,
    input  logic                         busy,
    input  logic                         override_en,
    input  logic [OVR_WIDTH-1:0]         override_value,
    input  logic                         error_clear,
    output logic [DATA_WIDTH-1:0]        gpo_out,
    output logic                         selected,
    output logic                         overrided,
    output logic                         busy_error,
    output logic [DATA_WIDTH-1:0]        error_data,
    output logic [1:0]                   error_sticky,
    output logic [CNT_WIDTH-1:0]         drop_count,
    output logic [$clog2(BUF_DEPTH):0]   buf_level
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;
    logic [OVR_WIDTH-1:0]  ovr_reg_q, ovr_reg_d;
    logic                  ovr_active_q, ovr_active_d;
    logic                  selected_q, selected_d;
    logic                  overrided_q, overrided_d;
    logic                  busy_error_q, busy_error_d;
    logic [DATA_WIDTH-1:0] error_data_q, error_data_d;
    logic [1:0]            sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    logic empty, full, pop, ev_ovr, ev_norm, bypass, push, ev_full, reject;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == LvlW'(BUF_DEPTH));
        // Pop and bypass both look at the registered override state, so the
        // first pop after release happens one cycle after ovr_active clears.
        pop     = !empty && !busy && !ovr_active_q;
        ev_ovr  = counter_matched && override_en;
        ev_norm = counter_matched && !override_en;
        bypass  = ev_norm && empty && !busy && !ovr_active_q;
        push    = ev_norm && !bypass && (!full || pop);
        ev_full = ev_norm && !bypass && full && !pop;
        reject  = ev_ovr || ev_full;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_reg_d    = out_reg_q;
        ovr_reg_d    = ovr_reg_q;
        ovr_active_d = ovr_active_q;
        selected_d   = pop || bypass;
        overrided_d  = ev_ovr;
        busy_error_d = ev_full;
        error_data_d = error_data_q;
        sticky_d     = sticky_q;
        drop_d       = drop_q;

        if (!busy) begin
            ovr_active_d = override_en;
            if (override_en) begin
                ovr_reg_d = override_value;
            end
        end

        if (pop) begin
            out_reg_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PtrW'(1);
        end else if (bypass) begin
            out_reg_d = gpo_in;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end

        // A rejection in the same cycle as error_clear wins.
        if (error_clear) begin
            sticky_d = 2'b00;
        end
        sticky_d[0] = sticky_d[0] | ev_full;
        sticky_d[1] = sticky_d[1] | ev_ovr;

        if (reject) begin
            error_data_d = gpo_in;
            if (error_clear) begin
                drop_d = CNT_WIDTH'(1);
            end else if (!(&drop_q)) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end else if (error_clear) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gpo_in;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_reg_q    <= '0;
            ovr_reg_q    <= '0;
            ovr_active_q <= 1'b0;
            selected_q   <= 1'b0;
            overrided_q  <= 1'b0;
            busy_error_q <= 1'b0;
            error_data_q <= '0;
            sticky_q     <= 2'b00;
            drop_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_reg_q    <= out_reg_d;
            ovr_reg_q    <= ovr_reg_d;
            ovr_active_q <= ovr_active_d;
            selected_q   <= selected_d;
            overrided_q  <= overrided_d;
            busy_error_q <= busy_error_d;
            error_data_q <= error_data_d;
            sticky_q     <= sticky_d;
            drop_q       <= drop_d;
        end
    end

    assign gpo_out      = ovr_active_q ? DATA_WIDTH'(ovr_reg_q) : out_reg_q;
    assign selected     = selected_q;
    assign overrided    = overrided_q;
    assign busy_error   = busy_error_q;
    assign error_data   = error_data_q;
    assign error_sticky = sticky_q;
    assign drop_count   = drop_q;
    assign buf_level    = level_q;

endmodule

// File: tb/tb_gpo_core_buffered.sv
// Directed table-driven bench for gpo_core_buffered; a second instance with a
// 2-bit drop counter shares the stimulus to exercise saturation.
module tb_gpo_core_buffered;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cm = 1'b0;
    logic [127:0] din = '0;
    logic         busy = 1'b0;
    logic         oen = 1'b0;
    logic [63:0]  oval = '0;
    logic         clr = 1'b0;

    logic [127:0] gpo_out, error_data, gpo_out2, error_data2;
    logic         selected, overrided, busy_error, selected2, overrided2, busy_error2;
    logic [1:0]   sticky, sticky2;
    logic [15:0]  drop;
    logic [1:0]   drop2;
    logic [2:0]   level, level2;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpo_core_buffered dut (
        .CLK100MHZ(clk), .resetn(resetn), .counter_matched(cm), .gpo_in(din), .busy(busy),
        .override_en(oen), .override_value(oval), .error_clear(clr), .gpo_out(gpo_out),
        .selected(selected), .overrided(overrided), .busy_error(busy_error),
        .error_data(error_data), .error_sticky(sticky), .drop_count(drop), .buf_level(level)
    );

    gpo_core_buffered #(.CNT_WIDTH(2)) dut2 (
        .CLK100MHZ(clk), .resetn(resetn), .counter_matched(cm), .gpo_in(din), .busy(busy),
        .override_en(oen), .override_value(oval), .error_clear(clr), .gpo_out(gpo_out2),
        .selected(selected2), .overrided(overrided2), .busy_error(busy_error2),
        .error_data(error_data2), .error_sticky(sticky2), .drop_count(drop2),
        .buf_level(level2)
    );

    typedef struct {
        logic         cm;
        logic [127:0] din;
        logic         busy;
        logic         oen;
        logic [63:0]  oval;
        logic         clr;
        logic [127:0] e_out;
        logic         e_sel;
        logic         e_ovr;
        logic         e_berr;
        logic [127:0] e_edata;
        logic [1:0]   e_st;
        logic [15:0]  e_dc;
        logic [2:0]   e_lv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic [127:0] d, input logic b, input logic o,
                       input logic [63:0] ov, input logic cl, input logic [127:0] eo,
                       input logic es, input logic eov, input logic eb,
                       input logic [127:0] ed, input logic [1:0] est, input logic [15:0] edc,
                       input logic [2:0] elv);
        vec_t v;
        v.cm = c; v.din = d; v.busy = b; v.oen = o; v.oval = ov; v.clr = cl;
        v.e_out = eo; v.e_sel = es; v.e_ovr = eov; v.e_berr = eb; v.e_edata = ed;
        v.e_st = est; v.e_dc = edc; v.e_lv = elv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [127:0] eo, input logic es,
                           input logic eov, input logic eb, input logic [127:0] ed,
                           input logic [1:0] est, input logic [15:0] edc, input logic [2:0] elv);
        chk({tag, ".gpo_out"}, gpo_out, eo);
        chk({tag, ".selected"}, 128'(selected), 128'(es));
        chk({tag, ".overrided"}, 128'(overrided), 128'(eov));
        chk({tag, ".busy_error"}, 128'(busy_error), 128'(eb));
        chk({tag, ".error_data"}, error_data, ed);
        chk({tag, ".sticky"}, 128'(sticky), 128'(est));
        chk({tag, ".drop_count"}, 128'(drop), 128'(edc));
        chk({tag, ".buf_level"}, 128'(level), 128'(elv));
    endtask

    task automatic drive(input logic c, input logic [127:0] d, input logic b, input logic o,
                         input logic [63:0] ov, input logic cl);
        @(negedge clk);
        cm = c; din = d; busy = b; oen = o; oval = ov; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cm din busy oen oval clr | gpo sel ovr berr edata sticky drop level
        add(1, 'hA5, 0, 0, 0, 0,      'hA5, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,         'hA5, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,         'hA5, 0, 0, 0, 0, 0, 0, 1);
        add(1, 2, 1, 0, 0, 0,         'hA5, 0, 0, 0, 0, 0, 0, 2);
        add(1, 3, 1, 0, 0, 0,         'hA5, 0, 0, 0, 0, 0, 0, 3);
        add(1, 4, 1, 0, 0, 0,         'hA5, 0, 0, 0, 0, 0, 0, 4);
        add(1, 5, 1, 0, 0, 0,         'hA5, 0, 0, 1, 5, 1, 1, 4);
        add(0, 0, 0, 0, 0, 0,         1, 1, 0, 0, 5, 1, 1, 3);
        add(0, 0, 0, 0, 0, 0,         2, 1, 0, 0, 5, 1, 1, 2);
        add(0, 0, 0, 0, 0, 0,         3, 1, 0, 0, 5, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0,         4, 1, 0, 0, 5, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,         4, 0, 0, 0, 5, 1, 1, 0);
        // Full FIFO with simultaneous push and pop
        add(1, 1, 1, 0, 0, 0,         4, 0, 0, 0, 5, 1, 1, 1);
        add(1, 2, 1, 0, 0, 0,         4, 0, 0, 0, 5, 1, 1, 2);
        add(1, 3, 1, 0, 0, 0,         4, 0, 0, 0, 5, 1, 1, 3);
        add(1, 4, 1, 0, 0, 0,         4, 0, 0, 0, 5, 1, 1, 4);
        add(1, 9, 0, 0, 0, 0,         1, 1, 0, 0, 5, 1, 1, 4);
        add(0, 0, 0, 0, 0, 0,         2, 1, 0, 0, 5, 1, 1, 3);
        add(0, 0, 0, 0, 0, 0,         3, 1, 0, 0, 5, 1, 1, 2);
        add(0, 0, 0, 0, 0, 0,         4, 1, 0, 0, 5, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0,         9, 1, 0, 0, 5, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,         9, 0, 0, 0, 5, 1, 1, 0);
        // Clear alone, then override collision
        add(0, 0, 0, 0, 0, 1,         9, 0, 0, 0, 5, 0, 0, 0);
        add(0, 0, 0, 1, 'hBEEF, 0,    'hBEEF, 0, 0, 0, 5, 0, 0, 0);
        add(1, 'h77, 0, 1, 'hBEEF, 0, 'hBEEF, 0, 1, 0, 'h77, 2, 1, 0);
        add(1, 'h22, 0, 0, 0, 0,      9, 0, 0, 0, 'h77, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0,         'h22, 1, 0, 0, 'h77, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0,         'h22, 0, 0, 0, 'h77, 2, 1, 0);
        // Clear colliding with an overflow
        add(1, 'hA, 1, 0, 0, 0,       'h22, 0, 0, 0, 'h77, 2, 1, 1);
        add(1, 'hB, 1, 0, 0, 0,       'h22, 0, 0, 0, 'h77, 2, 1, 2);
        add(1, 'hC, 1, 0, 0, 0,       'h22, 0, 0, 0, 'h77, 2, 1, 3);
        add(1, 'hD, 1, 0, 0, 0,       'h22, 0, 0, 0, 'h77, 2, 1, 4);
        add(1, 'hE, 1, 0, 0, 1,       'h22, 0, 0, 1, 'hE, 1, 1, 4);
        add(0, 0, 1, 0, 0, 1,         'h22, 0, 0, 0, 'hE, 0, 0, 4);
        // Override request held off by busy, then pop on the edge override engages
        add(0, 0, 1, 1, 'h1234, 0,    'h22, 0, 0, 0, 'hE, 0, 0, 4);
        add(0, 0, 0, 1, 'h1234, 0,    'h1234, 1, 0, 0, 'hE, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0,         'hA, 0, 0, 0, 'hE, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0,         'hB, 1, 0, 0, 'hE, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,         'hC, 1, 0, 0, 'hE, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,         'hD, 1, 0, 0, 'hE, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cm, vecs[i].din, vecs[i].busy, vecs[i].oen, vecs[i].oval,
                  vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_sel, vecs[i].e_ovr,
                    vecs[i].e_berr, vecs[i].e_edata, vecs[i].e_st, vecs[i].e_dc, vecs[i].e_lv);
        end

        // Saturation: fill, then five overflows
        for (int i = 1; i <= 4; i++) begin
            drive(1, 128'(i + 'h40), 1, 0, 0, 0);
            chk($sformatf("sat_fill%0d.level", i), 128'(level), 128'(i));
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1, 128'(i + 'h50), 1, 0, 0, 0);
            chk($sformatf("sat%0d.busy_error", i), 128'(busy_error), 128'(1));
            chk($sformatf("sat%0d.drop16", i), 128'(drop), 128'(i));
            chk($sformatf("sat%0d.drop2", i), 128'(drop2), 128'((i > 3) ? 3 : i));
        end
        chk("sat.error_data", error_data, 'h55);

        // Asynchronous reset mid-burst
        @(negedge clk);
        cm = 1'b1; din = 'h66; busy = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midreset.drop2", 128'(drop2), 0);
        cm = 1'b0; busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 'hA5, 0, 0, 0, 0);
        chk_all("post_reset", 'hA5, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_reset.sel_drop", 128'(selected), 0);
        chk("post_reset.hold", gpo_out, 'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpo_core_buffered.md
# gpo_core_buffered

Parametrised successor of the single-word GPO core: captures a timed output word on each counter match and presents it to the downstream DAC/GPO path. A BUF_DEPTH-entry FIFO absorbs events that arrive while downstream is busy, so only a full buffer raises a busy error. It also provides registered override, sticky error flags, a saturating drop counter and a buffer-level report. It sits between the AXI distribution logic and one output channel.

## Interface
- DATA_WIDTH, 128, width of timed output word gpo_in/gpo_out/error_data
- OVR_WIDTH, 64, width of override_value; must be ≤ DATA_WIDTH; zero-extended on output
- BUF_DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_WIDTH, 16, width of drop_count
- CLK100MHZ  in  1  the single clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- counter_matched  in  1  one-cycle event strobe; gpo_in valid in that cycle
- gpo_in  in  DATA_WIDTH  event word
- busy  in  1  downstream busy; gpo_out must not change while high
- override_en  in  1  level; request override of output
- override_value  in  OVR_WIDTH  override word
- error_clear  in  1  one-cycle pulse; clears error_sticky and drop_count
- gpo_out  out  DATA_WIDTH  current output word
- selected  out  1  one-cycle pulse: gpo_out took a new event word this cycle
- overrided  out  1  one-cycle pulse: event rejected because override active
- busy_error  out  1  one-cycle pulse: event rejected because FIFO full
- error_data  out  DATA_WIDTH  last rejected event word
- error_sticky  out  2  [0] overflow seen, [1] override collision seen
- drop_count  out  CNT_WIDTH  rejected events, saturating at all-ones
- buf_level  out  $clog2(BUF_DEPTH)+1  FIFO occupancy, 0..BUF_DEPTH

## Operation
- Reset (resetn low, any time, asynchronous): FIFO emptied, pointers 0, every output 0, override inactive; in-flight events lost.
- Override register: when busy low, ovr_active <= override_en and, if override_en, ovr_reg <= override_value. When busy high, both hold.
- gpo_out = ovr_active ? {zeros, ovr_reg} : out_reg.
- Event with override_en high (sampled input, not ovr_active): rejected; overrided pulse, error_data <= gpo_in, error_sticky[1] set, drop_count +1.
- Event otherwise: bypass if FIFO empty, busy low and ovr_active low (out_reg <= gpo_in, selected pulse); else pushed if FIFO not full or a pop occurs the same cycle; else rejected with busy_error pulse, error_data <= gpo_in, error_sticky[0] set, drop_count +1.
- Pop: when FIFO non-empty, busy low and ovr_active low, out_reg <= head, selected pulse; one pop per cycle; FIFO order preserved (bypass only when empty, so never reorders).
- Simultaneous push+pop on full FIFO: both accepted, level unchanged, no error. Push+pop on non-empty: level unchanged.
- FIFO contents retained during override and busy; draining resumes the cycle after both are low.
- Pointers wrap modulo BUF_DEPTH; buf_level is exact occupancy register.
- error_clear: clears error_sticky and drop_count; a rejection in the same cycle wins (flag set, drop_count = 1).
- drop_count holds at 2^CNT_WIDTH−1.

## Timing
- Bypass latency: counter_matched at edge N → gpo_out and selected valid after edge N+1 (1 cycle).
- Buffered latency: head issued on the first edge where busy and ovr_active are low; one word per cycle thereafter.
- overrided, busy_error, error_data, error_sticky, drop_count, buf_level update on the edge after the causing event.
- Override: override_en rising with busy low → gpo_out shows override value 1 cycle later; falling → out_reg shown 1 cycle later, pending FIFO head popped on the same edge ovr_active clears is not allowed (pop uses registered ovr_active), so first pop one cycle after release.
- All outputs registered except gpo_out mux.

## Test plan
- Reset: drive events, assert resetn low mid-burst → all outputs 0 immediately, buf_level 0; after release first event gpo_in=0xA5 bypasses, gpo_out=0xA5 one cycle later, selected pulse.
- Busy burst: busy high, 4 events 1..4 → buf_level 4, no errors; 5th event 5 → busy_error pulse, error_data=5, drop_count=1, sticky=01; busy low → gpo_out 1,2,3,4 on consecutive cycles, selected ×4.
- Full push+pop: FIFO full, busy falls same cycle as event 9 → no error, level stays 4, output order 1,2,3,4,9.
- Override collision: override_en high with value 0xBEEF, event 0x77 → gpo_out=0xBEEF, overrided pulse, error_data=0x77, sticky=10; buffered words drain after release.
- Clear vs error: error_clear and overflow same cycle → sticky[0]=1, drop_count=1; clear alone → 0.
- Saturation: CNT_WIDTH=2, 5 overflow events → drop_count=3.
